// File: rtl/tb_uart_mon_pkg.sv
// Shared types and constants for the testbench-side UART receive monitor.
// Pure declarations; no logic, no timing.
package tb_uart_mon_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

    localparam logic [7:0] LF_CHAR        = 8'h0A;
    localparam int         UART_DATA_BITS = 8;

endpackage

// File: rtl/tb_uart_mon_fifo.sv
// First-word-fall-through FIFO; push/pop take effect at the clock edge, head visible the cycle after a push.
// Push while full is accepted only when a pop frees a slot in the same cycle; otherwise push_ok_o stays low.
module tb_uart_mon_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    output logic             push_ok_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign pop_ok    = pop_i && !empty_o;
    assign push_ok   = push_i && (!full_o || pop_ok);
    assign push_ok_o = push_ok;
    assign count_o   = count_q;
    // Head is forced to zero while empty so the output has a defined reset value.
    assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/tb_uart_rx_monitor.sv
// 8N1 UART receiver feeding a FWFT byte FIFO; byte visible one cycle after its stop-bit sample.
// Consumer backpressure via ready_i; bytes arriving into a full FIFO are dropped and flagged sticky.
module tb_uart_rx_monitor
    import tb_uart_mon_pkg::*;
#(
    parameter  logic [31:0] CLK_FREQ   = 32'd100_000,
    parameter  logic [31:0] BAUD       = 32'd256_000,
    parameter  int          FIFO_DEPTH = 16,
    localparam int          CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rx_i,
    output logic [7:0]    data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [CW-1:0] count_o,
    output logic          line_o,
    output logic          frame_err_o,
    output logic          overflow_o,
    input  logic          clr_overflow_i
);

    localparam logic [63:0] CPB_WIDE     = (64'(CLK_FREQ) * 64'd1000) / 64'(BAUD);
    localparam int          CLKS_PER_BIT = int'(CPB_WIDE);
    localparam int          HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int          CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int          BIT_W        = $clog2(UART_DATA_BITS);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $fatal(1, "tb_uart_rx_monitor: CLKS_PER_BIT must be at least 4");
    end

    logic                      sync1_q;
    logic                      rx_s_q;
    rx_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      ferr_q, ferr_d;
    logic                      line_q, line_d;
    logic                      ovf_q, ovf_d;
    logic                      push;
    logic                      push_ok;
    logic                      fifo_full;
    logic                      fifo_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            rx_s_q  <= sync1_q;
        end
    end

    // cnt_q counts cycles since the last sample point; it is 1 on the cycle after T0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = CNT_W'(1);
                    bit_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_W'(HALF_BIT)) begin
                    cnt_d   = CNT_W'(1);
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT)) begin
                    cnt_d   = CNT_W'(1);
                    shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT)) begin
                    cnt_d = CNT_W'(1);
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        line_d = push_ok && (shift_q == LF_CHAR);
        ovf_d  = ovf_q;
        if (clr_overflow_i) begin
            ovf_d = 1'b0;
        end
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            line_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            line_q  <= line_d;
            ovf_q   <= ovf_d;
        end
    end

    tb_uart_mon_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (push),
        .push_dat_i (shift_q),
        .push_ok_o  (push_ok),
        .pop_i      (ready_i),
        .pop_dat_o  (data_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (count_o)
    );

    assign valid_o     = !fifo_empty;
    assign line_o      = line_q;
    assign frame_err_o = ferr_q;
    assign overflow_o  = ovf_q;

endmodule
